// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared encodings for the keypad matrix scanner: event types, FSM states, frame results.
package keypad_matrix_scanner_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_type_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_PRESS_DB = 4'b0010,
    ST_HELD     = 4'b0100,
    ST_REL_DB   = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_res_t;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Event port toward the front-panel controller: valid/ready with key code and event type.
interface keypad_matrix_scanner_if
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int CODE_W = 4
) ();

  logic              o_evt_valid;
  logic              i_evt_ready;
  logic [CODE_W-1:0] o_evt_code;
  evt_type_t         o_evt_type;

  modport master (output o_evt_valid, output o_evt_code, output o_evt_type, input i_evt_ready);
  modport slave  (input o_evt_valid, input o_evt_code, input o_evt_type, output i_evt_ready);

endinterface

// File: rtl/keypad_matrix_scanner_column_scan.sv
// Column driver, row synchroniser and per-frame NONE/SINGLE/MULTI classification.
module keypad_matrix_scanner_column_scan
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ROWS-1:0]   i_rows,
  output logic [COLS-1:0]   o_columns,
  output logic              o_frame_stb,
  output frame_res_t        o_frame_res,
  output logic [CODE_W-1:0] o_frame_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = $clog2(COLS);

  logic [DIV_W-1:0]  r_dwell;
  logic [COL_W-1:0]  r_col;
  logic [ROWS-1:0]   r_rows_meta;
  logic [ROWS-1:0]   r_rows_sync;
  logic [1:0]        r_acc_cnt;
  logic [CODE_W-1:0] r_acc_code;
  logic              r_frame_stb;
  frame_res_t        r_frame_res;
  logic [CODE_W-1:0] r_frame_code;

  logic              w_sample;
  logic              w_last_col;
  logic [1:0]        w_col_cnt;
  logic [CODE_W-1:0] w_col_code;
  logic [2:0]        w_tot;
  logic [1:0]        w_sum_cnt;
  logic [CODE_W-1:0] w_sum_code;

  assign w_sample   = (r_dwell == DIV_W'(SCAN_DIV - 1));
  assign w_last_col = (r_col == COL_W'(COLS - 1));

  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      o_columns[c] = (r_col != COL_W'(c));
    end
  end

  // Key counts saturate at 2: only none/one/many matters for the frame result.
  always_comb begin
    w_col_cnt  = 2'd0;
    w_col_code = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!r_rows_sync[r]) begin
        if (w_col_cnt == 2'd0) w_col_code = CODE_W'(r_col * ROWS + r);
        if (w_col_cnt != 2'd2) w_col_cnt = w_col_cnt + 2'd1;
      end
    end
    w_tot      = {1'b0, r_acc_cnt} + {1'b0, w_col_cnt};
    w_sum_cnt  = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
    w_sum_code = (r_acc_cnt != 2'd0) ? r_acc_code : w_col_code;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rows_meta  <= '1;
      r_rows_sync  <= '1;
      r_dwell      <= '0;
      r_col        <= '0;
      r_acc_cnt    <= '0;
      r_acc_code   <= '0;
      r_frame_stb  <= 1'b0;
      r_frame_res  <= FRAME_NONE;
      r_frame_code <= '0;
    end else begin
      r_rows_meta <= i_rows;
      r_rows_sync <= r_rows_meta;
      r_frame_stb <= 1'b0;
      if (w_sample) begin
        r_dwell <= '0;
        if (w_last_col) begin
          r_col        <= '0;
          r_acc_cnt    <= '0;
          r_acc_code   <= '0;
          r_frame_stb  <= 1'b1;
          r_frame_code <= w_sum_code;
          case (w_sum_cnt)
            2'd0:    r_frame_res <= FRAME_NONE;
            2'd1:    r_frame_res <= FRAME_SINGLE;
            default: r_frame_res <= FRAME_MULTI;
          endcase
        end else begin
          r_col      <= r_col + 1'b1;
          r_acc_cnt  <= w_sum_cnt;
          r_acc_code <= w_sum_code;
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign o_frame_stb  = r_frame_stb;
  assign o_frame_res  = r_frame_res;
  assign o_frame_code = r_frame_code;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner top: debounce/auto-repeat FSM and single-entry event output register.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ROWS-1:0]        i_rows,
  output logic [COLS-1:0]        o_columns,
  keypad_matrix_scanner_if.master evt,
  output logic                   o_held,
  output logic                   o_multi,
  output logic                   o_drop
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int CNT_W  = cnt_width(DEBOUNCE);
  localparam int RD_W   = cnt_width(REPEAT_DELAY);
  localparam int RT_W   = cnt_width(REPEAT_RATE);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state;
  state_t            w_next_state;
  logic [CODE_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [RD_W-1:0]   r_rcnt;
  logic [RT_W-1:0]   r_rrate;
  logic              r_multi;
  logic              r_drop;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  evt_type_t         r_type;

  logic              w_stb;
  frame_res_t        w_res;
  logic [CODE_W-1:0] w_code;
  logic              w_same;
  logic              w_gone;
  logic              w_cnt_done;
  logic              w_emit;
  evt_type_t         w_emit_type;
  logic [CODE_W-1:0] w_cand_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [RD_W-1:0]   w_rcnt_nxt;
  logic [RT_W-1:0]   w_rrate_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  keypad_matrix_scanner_column_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .CODE_W   (CODE_W)
  ) u_scan (
    .i_clk        (i_clk),
    .i_rst_n      (w_rst_n),
    .i_rows       (i_rows),
    .o_columns    (o_columns),
    .o_frame_stb  (w_stb),
    .o_frame_res  (w_res),
    .o_frame_code (w_code)
  );

  assign w_same     = (w_res == FRAME_SINGLE) && (w_code == r_cand);
  assign w_gone     = (w_res == FRAME_NONE) || ((w_res == FRAME_SINGLE) && (w_code != r_cand));
  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE - 1));

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // A MULTI frame during release debounce neither confirms nor cancels the release.
  always_comb begin
    w_next_state = r_state;
    if (w_stb) begin
      unique case (r_state)
        ST_IDLE:     if (w_res == FRAME_SINGLE) w_next_state = (DEBOUNCE == 1) ? ST_HELD : ST_PRESS_DB;
        ST_PRESS_DB: begin
          if (!w_same)         w_next_state = ST_IDLE;
          else if (w_cnt_done) w_next_state = ST_HELD;
        end
        ST_HELD:     if (w_gone) w_next_state = (DEBOUNCE == 1) ? ST_IDLE : ST_REL_DB;
        ST_REL_DB: begin
          if (w_same)                    w_next_state = ST_HELD;
          else if (w_gone && w_cnt_done) w_next_state = ST_IDLE;
        end
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_emit      = 1'b0;
    w_emit_type = EVT_PRESS;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_rrate_nxt = r_rrate;
    if (w_stb) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_res == FRAME_SINGLE) begin
            w_cand_nxt  = w_code;
            w_cnt_nxt   = CNT_W'(1);
            w_rcnt_nxt  = '0;
            w_rrate_nxt = '0;
            w_emit      = (DEBOUNCE == 1);
          end
        end
        ST_PRESS_DB: begin
          if (w_same) begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_emit    = w_cnt_done;
          end
        end
        ST_HELD: begin
          if (w_gone) begin
            w_cnt_nxt   = CNT_W'(1);
            w_emit      = (DEBOUNCE == 1);
            w_emit_type = EVT_RELEASE;
          end else if (REPEAT_DELAY != 0) begin
            w_emit_type = EVT_REPEAT;
            if (r_rcnt != RD_W'(REPEAT_DELAY)) begin
              w_rcnt_nxt  = r_rcnt + 1'b1;
              w_rrate_nxt = '0;
              w_emit      = (r_rcnt == RD_W'(REPEAT_DELAY - 1));
            end else if (r_rrate == RT_W'(REPEAT_RATE - 1)) begin
              w_rrate_nxt = '0;
              w_emit      = 1'b1;
            end else begin
              w_rrate_nxt = r_rrate + 1'b1;
            end
          end
        end
        ST_REL_DB: begin
          if (w_gone) begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_emit      = w_cnt_done;
            w_emit_type = EVT_RELEASE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cand  <= '0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_rrate <= '0;
      r_multi <= 1'b0;
      r_drop  <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_type  <= EVT_PRESS;
    end else begin
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rrate <= w_rrate_nxt;
      r_drop  <= 1'b0;
      if (w_stb) r_multi <= (w_res == FRAME_MULTI);
      if (w_emit) begin
        if (!r_valid || evt.i_evt_ready) begin
          r_valid <= 1'b1;
          r_code  <= w_cand_nxt;
          r_type  <= w_emit_type;
        end else begin
          r_drop <= 1'b1;
        end
      end else if (evt.i_evt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.o_evt_valid = r_valid;
  assign evt.o_evt_code  = r_code;
  assign evt.o_evt_type  = r_type;
  assign o_held          = (r_state == ST_HELD) || (r_state == ST_REL_DB);
  assign o_multi         = r_multi;
  assign o_drop          = r_drop;

endmodule
